// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the register dump block.
// Holds the dump FSM state encoding and default datapath widths.
package lc3_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Register-file read-port arbitration plus the dumped-word output stream.
// master = dump controller, slave = register file/arbiter and word consumer.
interface reg_dump_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              Reg_Req;
    logic              Reg_Gnt;
    logic [ADDR_W-1:0] Rd_Sel;
    logic [DATA_W-1:0] Rd_Data;
    logic [DATA_W-1:0] Out_Data;
    logic [ADDR_W-1:0] Out_Idx;
    logic              Out_Valid;
    logic              Out_Ready;

    modport master (
        output Reg_Req, Rd_Sel, Out_Data, Out_Idx, Out_Valid,
        input  Reg_Gnt, Rd_Data, Out_Ready
    );

    modport slave (
        input  Reg_Req, Rd_Sel, Out_Data, Out_Idx, Out_Valid,
        output Reg_Gnt, Rd_Data, Out_Ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// Purpose: walk R0..R[NUM_REGS-1] through a shared read port and stream each word out.
// Latency: 2 cycles per word minimum (REQ+grant, SEND+ready); Done 2*NUM_REGS+1 cycles after first REQ.
// Backpressure: word held stable in SEND until Out_Ready; no grant keeps it waiting in REQ.
module reg_dump_ctrl
    import lc3_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    output logic            Busy,
    output logic            Done,
    reg_dump_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [ADDR_W-1:0] out_idx_q, out_idx_nxt;
    logic [DATA_W-1:0] out_data_q, out_data_nxt;
    logic              out_vld_q, out_vld_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            out_idx_q  <= out_idx_nxt;
            out_data_q <= out_data_nxt;
            out_vld_q  <= out_vld_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        out_idx_nxt  = out_idx_q;
        out_data_nxt = out_data_q;
        out_vld_nxt  = out_vld_q;
        case (state)
            IDLE: begin
                if (Start) begin
                    idx_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Capture only here, so a grant held high never double-captures.
                if (bus.Reg_Gnt) begin
                    out_data_nxt = bus.Rd_Data;
                    out_idx_nxt  = idx;
                    out_vld_nxt  = 1'b1;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (out_vld_q && bus.Out_Ready) begin
                    out_vld_nxt = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Reg_Req   = (state == REQ);
    assign bus.Rd_Sel    = (state == REQ) ? idx : '0;
    assign bus.Out_Data  = out_data_q;
    assign bus.Out_Idx   = out_idx_q;
    assign bus.Out_Valid = out_vld_q;
    assign Busy          = (state != IDLE);
    assign Done          = (state == FIN);

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboarded bench for reg_dump_ctrl: directed corner cases plus randomized grant/ready dumps.
module tb_reg_dump_ctrl;

    localparam int NREG = 8;

    logic Clk = 1'b0;
    logic Reset_n;
    logic Start;
    logic Busy;
    logic Done;

    reg_dump_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg_dump_ctrl #(.NUM_REGS(NREG), .DATA_W(16), .ADDR_W(3)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Busy    (Busy),
        .Done    (Done),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    logic [15:0] regs [NREG];
    assign bus.Rd_Data = regs[bus.Rd_Sel];

    logic gnt_force, gnt_val, gnt_rnd;
    logic rdy_force, rdy_val, rdy_rnd;
    always_comb bus.Reg_Gnt   = gnt_force ? gnt_val : gnt_rnd;
    always_comb bus.Out_Ready = rdy_force ? rdy_val : rdy_rnd;

    initial begin
        gnt_rnd = 1'b0;
        rdy_rnd = 1'b0;
    end
    always @(posedge Clk) begin
        #1;
        gnt_rnd = ($urandom_range(0, 99) < 60);
        rdy_rnd = ($urandom_range(0, 99) < 50);
    end

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Monitor: pops the scoreboard on every accepted word and watches protocol rules.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [2:0]  prev_idx;
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("valid_held", 32'(bus.Out_Valid), 32'd1);
                chk("data_held", 32'(bus.Out_Data), 32'(prev_data));
                chk("idx_held", 32'(bus.Out_Idx), 32'(prev_idx));
            end
            if (bus.Out_Valid && bus.Out_Ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_idx", 32'(bus.Out_Idx), 32'(e.idx));
                    chk("word_data", 32'(bus.Out_Data), 32'(e.data));
                end
            end
            if (!bus.Reg_Req) chk("rd_sel_idle_zero", 32'(bus.Rd_Sel), 32'd0);
            if (bus.Out_Valid) chk("no_req_while_valid", 32'(bus.Reg_Req), 32'd0);
            if (Done) done_cnt++;
            prev_stall = bus.Out_Valid && !bus.Out_Ready;
            prev_data  = bus.Out_Data;
            prev_idx   = bus.Out_Idx;
        end
    end

    // Expected words: register contents, with one optional register changed before it is read.
    task automatic push_dump(input int mod_i, input logic [15:0] mod_v);
        for (int i = 0; i < NREG; i++) begin
            exp_t e;
            e.idx  = i;
            e.data = (i == mod_i) ? mod_v : regs[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic start_dump();
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge Clk);
            if (Done) break;
            n++;
        end
        if (n >= budget) fail_now("done_timeout");
        @(negedge Clk);
    endtask

    task automatic wait_valid_idx(input int i);
        int n;
        n = 0;
        while (n < 500) begin
            @(negedge Clk);
            if (bus.Out_Valid && bus.Out_Idx == 3'(i)) break;
            n++;
        end
        if (n >= 500) fail_now("wait_valid_timeout");
    endtask

    task automatic wait_req_sel(input int i);
        int n;
        n = 0;
        while (n < 500) begin
            @(negedge Clk);
            if (bus.Reg_Req && bus.Rd_Sel == 3'(i)) break;
            n++;
        end
        if (n >= 500) fail_now("wait_req_timeout");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_req"}, 32'(bus.Reg_Req), 32'd0);
        chk({tag, "_sel"}, 32'(bus.Rd_Sel), 32'd0);
        chk({tag, "_valid"}, 32'(bus.Out_Valid), 32'd0);
        chk({tag, "_data"}, 32'(bus.Out_Data), 32'd0);
        chk({tag, "_idx"}, 32'(bus.Out_Idx), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int busy_cycles;
        Reset_n   = 1'b0;
        Start     = 1'b0;
        gnt_force = 1'b1;
        gnt_val   = 1'b1;
        rdy_force = 1'b1;
        rdy_val   = 1'b1;
        for (int i = 0; i < NREG; i++) regs[i] = 16'h1000 + 16'(i);

        #12;
        chk_all_zero("reset");
        Reset_n = 1'b1;

        // Full-speed dump: 2*NREG+1 busy cycles, Busy drops with the end of Done.
        d0 = done_cnt;
        push_dump(-1, 16'h0);
        start_dump();
        busy_cycles = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk);
            if (Busy) busy_cycles++;
            if (Done) break;
        end
        chk("fullspeed_busy_cycles", 32'(busy_cycles), 32'(2 * NREG + 1));
        @(negedge Clk);
        chk("fullspeed_busy_after_done", 32'(Busy), 32'd0);
        chk("fullspeed_done_count", 32'(done_cnt - d0), 32'd1);
        chk("fullspeed_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure on R3.
        regs[3] = 16'hBEEF;
        d0 = done_cnt;
        push_dump(-1, 16'h0);
        start_dump();
        wait_req_sel(3);
        @(posedge Clk); #1;
        rdy_val = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            chk("bp_valid", 32'(bus.Out_Valid), 32'd1);
            chk("bp_data", 32'(bus.Out_Data), 32'hBEEF);
        end
        @(posedge Clk); #1;
        rdy_val = 1'b1;
        wait_done(200);
        chk("bp_done_count", 32'(done_cnt - d0), 32'd1);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Grant starvation at idx 2.
        d0 = done_cnt;
        push_dump(-1, 16'h0);
        start_dump();
        wait_valid_idx(1);
        @(posedge Clk); #1;
        gnt_val = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            chk("starve_req", 32'(bus.Reg_Req), 32'd1);
            chk("starve_sel", 32'(bus.Rd_Sel), 32'd2);
            chk("starve_valid", 32'(bus.Out_Valid), 32'd0);
        end
        @(posedge Clk); #1;
        gnt_val = 1'b1;
        @(posedge Clk); #1;
        chk("starve_capture_valid", 32'(bus.Out_Valid), 32'd1);
        chk("starve_capture_idx", 32'(bus.Out_Idx), 32'd2);
        wait_done(200);
        chk("starve_done_count", 32'(done_cnt - d0), 32'd1);

        // Start pulses while busy are ignored and not queued.
        d0 = done_cnt;
        push_dump(-1, 16'h0);
        start_dump();
        wait_valid_idx(4);
        @(posedge Clk); #1;
        Start = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_done(200);
        chk("busystart_done_count", 32'(done_cnt - d0), 32'd1);
        chk("busystart_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) begin
            @(negedge Clk);
            chk("busystart_stays_idle", 32'(Busy), 32'd0);
        end

        // Asynchronous reset in SEND at word 5.
        d0 = done_cnt;
        push_dump(-1, 16'h0);
        start_dump();
        wait_req_sel(5);
        @(posedge Clk); #1;
        rdy_val = 1'b0;
        @(negedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        @(negedge Clk); #2;
        Reset_n = 1'b1;
        rdy_val = 1'b1;
        repeat (3) @(negedge Clk);
        chk("async_rst_no_done", 32'(done_cnt - d0), 32'd0);

        // Register changed by the datapath before its REQ: sampled at grant time.
        for (int i = 0; i < NREG; i++) regs[i] = 16'(i);
        d0 = done_cnt;
        push_dump(6, 16'hAAAA);
        start_dump();
        wait_valid_idx(5);
        regs[6] = 16'hAAAA;
        wait_done(200);
        chk("modreg_done_count", 32'(done_cnt - d0), 32'd1);
        chk("modreg_queue_empty", 32'(exp_q.size()), 32'd0);

        // Randomized grant/ready with random register contents.
        gnt_force = 1'b0;
        rdy_force = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREG; i++) regs[i] = 16'($urandom);
            d0 = done_cnt;
            push_dump(-1, 16'h0);
            start_dump();
            wait_done(3000);
            chk("rand_done_count", 32'(done_cnt - d0), 32'd1);
            chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
            repeat ($urandom_range(0, 3)) @(posedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
Sequential reader that walks the 8-entry LC-3 general-purpose register file and streams every register out over a valid/ready handshake. Typical consumers are the hex-display driver and the debug serial path. It borrows one register-file read-select port through a request/grant arbiter shared with the datapath. It only ever reads from the register file and never writes to it.

Parameters:
NUM_REGS, 8, number of registers scanned (R0..R[NUM_REGS-1])
DATA_W, 16, register word width
ADDR_W, 3, register select width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  single-cycle request to begin a dump; sampled only in IDLE
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse after the last word is accepted
Reg_Req  out  1  request for the shared register-file read-select port
Reg_Gnt  in  1  grant from the arbiter; combinational read is valid in the same cycle
Rd_Sel  out  ADDR_W  register select driven to the register file read port
Rd_Data  in  DATA_W  combinational read data for Rd_Sel
Out_Data  out  DATA_W  captured register word
Out_Idx  out  ADDR_W  index of the register in Out_Data
Out_Valid  out  1  Out_Data/Out_Idx are valid
Out_Ready  in  1  consumer accepts the word when Out_Valid && Out_Ready at a rising edge

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, idx=0, Out_Data=0, Out_Idx=0, Out_Valid=0, Reg_Req=0, Done=0, Busy=0, Rd_Sel=0. Reset mid-dump abandons the dump. No partial Done. Restart requires a new Start.
- FSM states are IDLE, REQ, SEND and FIN.
- IDLE: on Start=1, set idx<=0 and go to REQ. Otherwise stay.
- REQ: Reg_Req=1 and Rd_Sel=idx, both driven combinationally from state and idx. On the first edge with Reg_Gnt=1: Out_Data<=Rd_Data, Out_Idx<=idx, Out_Valid<=1, go to SEND. Without a grant, stay in REQ indefinitely; there is no timeout.
- SEND: Reg_Req=0 and Out_Valid=1. Out_Data and Out_Idx are held stable until the handshake completes.
  - On Out_Valid && Out_Ready with idx==NUM_REGS-1: Out_Valid<=0, go to FIN.
  - On Out_Valid && Out_Ready otherwise: Out_Valid<=0, idx<=idx+1, go to REQ.
- FIN: Done=1 for exactly one cycle, then go to IDLE.
- Out_Valid never deasserts without a handshake, except on reset.
- Rd_Sel is 0 outside REQ.
- Start is ignored while Busy=1; it is not queued.
- Minimum per-word cost is 2 cycles (REQ with immediate grant, then SEND with Ready already high).
- Minimum full dump is 2*NUM_REGS+1 cycles from the first REQ cycle to the Done cycle inclusive. With the defaults, Start to Done is 18 edges.
- idx never wraps. Termination relies on the NUM_REGS-1 compare, so NUM_REGS < 2**ADDR_W is legal.
- Out_Ready high during REQ has no effect.
- A grant held across multiple cycles does not cause double capture, because capture occurs only in REQ.

Decomposition:
- Shared package lc3_pkg holds:
  - the state enum dump_state_t {IDLE, REQ, SEND, FIN};
  - the default DATA_W=16 and ADDR_W=3 constants.
- A single flat module is sufficient. The output holding register is the only storage beyond the FSM and idx, so no sub-module is needed.

Test Plan:
- Preload R0..R7 = 16'h1000..16'h1007. Hold Reg_Gnt=1 and Out_Ready=1, pulse Start -> 8 handshakes with Out_Idx 0..7 and Out_Data 16'h1000..16'h1007 in order. Done pulses once, 18 edges after Start. Busy falls with Done.
- Backpressure: Out_Ready=0 for 5 cycles at word R3=16'hBEEF -> Out_Valid stays 1 and Out_Data stays 16'hBEEF unchanged. Exactly one transfer occurs when Ready rises.
- Grant starvation: Reg_Gnt=0 for 10 cycles while in REQ with idx=2 -> Reg_Req=1, Rd_Sel=2, Out_Valid=0 throughout. Capture happens on the first grant cycle.
- Start pulses while Busy (at word 4) -> ignored. Exactly 8 words and one Done. A Start after Done begins a fresh dump from R0.
- Reset_n low asynchronously mid-SEND at word 5 -> all outputs return to 0 immediately without waiting for a clock edge. No Done is produced, and the next dump starts at R0.
- Register modified by the datapath between words (R6 changes 16'h0006 to 16'hAAAA before its REQ) -> the dump reports 16'hAAAA. Data is sampled at grant time, not at Start.
